order_book_dispatch_ctrl: RTL and testbench

- Sequencer between the inbound 320-bit order-message FIFO, the shared order_book_parser, and the buy-side and sell-side book engines.
- Pops one message at a time and presents it to the parser, waiting for ready or a timeout.
- Validates the decoded request type and side, then hands the order to the matching engine over a valid/ready handshake.
- Drops malformed messages and counts both dispatched and dropped messages.

---
 rtl/order_book_dispatch_ctrl_if.sv | 52 +++++
 rtl/order_book_dispatch_ctrl.sv | 150 +++++++++++++++
 tb/tb_order_book_dispatch_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_book_dispatch_ctrl_if.sv
// Bus bundle between the dispatch controller, the inbound order FIFO,
// the shared order parser and the buy/sell book engines.
interface order_book_dispatch_ctrl_if #(
    parameter int MSG_W = 320
);
    // Inbound message FIFO
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [MSG_W-1:0]  fifo_dout;
    // Shared parser
    logic              par_valid;
    logic [MSG_W-1:0]  par_buffer;
    logic              par_ready;
    logic [7:0]        par_req_type;
    logic [31:0]       par_order_id;
    logic [31:0]       par_stock_id;
    logic [31:0]       par_quantity;
    logic [63:0]       par_price;
    logic [7:0]        par_side;
    // Book engines
    logic              buy_valid;
    logic              buy_ready;
    logic              sell_valid;
    logic              sell_ready;
    logic [7:0]        ord_req_type;
    logic [31:0]       ord_order_id;
    logic [31:0]       ord_stock_id;
    logic [31:0]       ord_quantity;
    logic [63:0]       ord_price;

    // Controller side
    modport master (
        input  fifo_empty, fifo_dout,
        input  par_ready, par_req_type, par_order_id, par_stock_id,
        input  par_quantity, par_price, par_side,
        input  buy_ready, sell_ready,
        output fifo_rd_en, par_valid, par_buffer,
        output buy_valid, sell_valid,
        output ord_req_type, ord_order_id, ord_stock_id, ord_quantity, ord_price
    );

    // Environment side (FIFO, parser, engines)
    modport slave (
        output fifo_empty, fifo_dout,
        output par_ready, par_req_type, par_order_id, par_stock_id,
        output par_quantity, par_price, par_side,
        output buy_ready, sell_ready,
        input  fifo_rd_en, par_valid, par_buffer,
        input  buy_valid, sell_valid,
        input  ord_req_type, ord_order_id, ord_stock_id, ord_quantity, ord_price
    );
endinterface

// File: rtl/order_book_dispatch_ctrl.sv
// Order book dispatch controller: pops one order message at a time from the
// inbound FIFO, runs it through the shared parser, validates the decoded
// request type and side and hands legal orders to the buy or sell engine.
// Malformed or unparsed messages are dropped; both outcomes are counted.
module order_book_dispatch_ctrl #(
    parameter int MSG_W         = 320,
    parameter int PARSE_TIMEOUT = 16,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    order_book_dispatch_ctrl_if.master bus,
    output logic                       busy,
    output logic [CNT_W-1:0]           msg_count,
    output logic [CNT_W-1:0]           drop_count
);
    localparam int TMR_W = $clog2(PARSE_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PARSE_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_PARSE    = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_DISPATCH = 3'd4;
    localparam logic [2:0] S_DROP     = 3'd5;

    localparam logic [7:0] REQ_ADD    = 8'h41;
    localparam logic [7:0] REQ_MODIFY = 8'h4D;
    localparam logic [7:0] REQ_DELETE = 8'h44;
    localparam logic [7:0] SIDE_BUY   = 8'h42;
    localparam logic [7:0] SIDE_SELL  = 8'h53;

    logic [2:0]       r_state;
    logic [MSG_W-1:0] r_par_buffer;
    logic             r_par_valid;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_side;
    logic [7:0]       r_req_type;
    logic [31:0]      r_order_id;
    logic [31:0]      r_stock_id;
    logic [31:0]      r_quantity;
    logic [63:0]      r_price;
    logic             r_buy_valid;
    logic             r_sell_valid;
    logic [CNT_W-1:0] r_msg_count;
    logic [CNT_W-1:0] r_drop_count;

    logic             w_req_legal;
    logic             w_side_legal;
    logic             w_side_buy;
    logic             w_handshake;

    // Statistics counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign w_req_legal  = (r_req_type == REQ_ADD) || (r_req_type == REQ_MODIFY) ||
                          (r_req_type == REQ_DELETE);
    assign w_side_buy   = (r_side == SIDE_BUY);
    assign w_side_legal = w_side_buy || (r_side == SIDE_SELL);
    // Only the selected engine's ready matters; the other valid is low.
    assign w_handshake  = (r_buy_valid && bus.buy_ready) || (r_sell_valid && bus.sell_ready);

    // The pop strobe is combinational so the FIFO data lands during LOAD.
    assign bus.fifo_rd_en   = !reset && (r_state == S_IDLE) && !bus.fifo_empty;
    assign bus.par_valid    = r_par_valid;
    assign bus.par_buffer   = r_par_buffer;
    assign bus.buy_valid    = r_buy_valid;
    assign bus.sell_valid   = r_sell_valid;
    assign bus.ord_req_type = r_req_type;
    assign bus.ord_order_id = r_order_id;
    assign bus.ord_stock_id = r_stock_id;
    assign bus.ord_quantity = r_quantity;
    assign bus.ord_price    = r_price;
    assign busy             = (r_state != S_IDLE);
    assign msg_count        = r_msg_count;
    assign drop_count       = r_drop_count;

    // Message sequencer: fetch, parse with timeout, validate, dispatch or drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_par_buffer <= '0;
            r_par_valid  <= 1'b0;
            r_timer      <= '0;
            r_side       <= '0;
            r_req_type   <= '0;
            r_order_id   <= '0;
            r_stock_id   <= '0;
            r_quantity   <= '0;
            r_price      <= '0;
            r_buy_valid  <= 1'b0;
            r_sell_valid <= 1'b0;
            r_msg_count  <= '0;
            r_drop_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.fifo_empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_par_buffer <= bus.fifo_dout;
                    r_par_valid  <= 1'b1;
                    r_timer      <= '0;
                    r_state      <= S_PARSE;
                end
                S_PARSE: begin
                    r_timer <= r_timer + TMR_W'(1);
                    // A ready arriving on the last timeout cycle still wins.
                    if (bus.par_ready) begin
                        r_req_type  <= bus.par_req_type;
                        r_order_id  <= bus.par_order_id;
                        r_stock_id  <= bus.par_stock_id;
                        r_quantity  <= bus.par_quantity;
                        r_price     <= bus.par_price;
                        r_side      <= bus.par_side;
                        r_par_valid <= 1'b0;
                        r_state     <= S_CHECK;
                    end else if (r_timer == TMR_LAST) begin
                        r_par_valid <= 1'b0;
                        r_state     <= S_DROP;
                    end
                end
                S_CHECK: begin
                    if (w_req_legal && w_side_legal) begin
                        r_buy_valid  <= w_side_buy;
                        r_sell_valid <= !w_side_buy;
                        r_state      <= S_DISPATCH;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_DISPATCH: begin
                    if (w_handshake) begin
                        r_buy_valid  <= 1'b0;
                        r_sell_valid <= 1'b0;
                        r_msg_count  <= sat_inc(r_msg_count);
                        r_state      <= S_IDLE;
                    end
                end
                S_DROP: begin
                    r_drop_count <= sat_inc(r_drop_count);
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_order_book_dispatch_ctrl.sv
// Self-checking bench for order_book_dispatch_ctrl. Messages carry their own
// parser latency (bits 183:176) and engine stall (bits 191:184) so the parser
// and engine models can act on par_buffer alone. A scoreboard queue holds the
// expected outcome of every message; a monitor pops it on each dispatch/drop.
module tb_order_book_dispatch_ctrl;
    localparam int MSG_W = 320;
    localparam int PT    = 16;
    localparam int CNT_W = 16;

    typedef struct {
        bit          drop;
        bit          buy;
        bit          parsed;
        logic [7:0]  t;
        logic [31:0] oid;
        logic [31:0] sid;
        logic [31:0] qty;
        logic [63:0] price;
        int          stall;
        int          pv_len;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             busy;
    logic [CNT_W-1:0] msg_count;
    logic [CNT_W-1:0] drop_count;

    order_book_dispatch_ctrl_if #(.MSG_W(MSG_W)) bus ();

    order_book_dispatch_ctrl #(.MSG_W(MSG_W), .PARSE_TIMEOUT(PT), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .msg_count  (msg_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    int               model_msg = 0;
    int               model_drop = 0;
    int               cyc = 0;
    exp_t             exp_q[$];
    logic [MSG_W-1:0] fifo_q[$];
    int               rd_times[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Build a message, derive its expected outcome from the protocol rules, queue both.
    task automatic send(input logic [7:0] t, input logic [7:0] s, input logic [31:0] qty,
                        input logic [63:0] pr, input int d, input int stall);
        exp_t             e;
        logic [MSG_W-1:0] m;
        for (int i = 0; i < MSG_W / 32; i++) m[i*32 +: 32] = $urandom;
        m[7:0]     = t;
        m[15:8]    = s;
        m[111:80]  = qty;
        m[175:112] = pr;
        m[183:176] = d[7:0];
        m[191:184] = stall[7:0];
        e.t      = t;
        e.oid    = m[47:16];
        e.sid    = m[79:48];
        e.qty    = qty;
        e.price  = pr;
        e.parsed = (d < PT);
        e.drop   = !((t inside {8'h41, 8'h4D, 8'h44}) && (s inside {8'h42, 8'h53})) || !e.parsed;
        e.buy    = (s == 8'h42);
        e.stall  = stall;
        e.pv_len = e.parsed ? d + 1 : PT;
        @(negedge clk);
        exp_q.push_back(e);
        fifo_q.push_back(m);
        if (e.drop) model_drop++;
        else        model_msg++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({"drain_", tag}, exp_q.size(), 0);
        repeat (3) @(negedge clk);
        check({"msg_count_", tag}, msg_count, model_msg);
        check({"drop_count_", tag}, drop_count, model_drop);
        check({"idle_", tag}, busy, 0);
    endtask

    // FIFO model: data appears the cycle after a sampled pop.
    initial begin
        bit rd;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        forever begin
            @(negedge clk);
            rd = bus.fifo_rd_en;
            @(posedge clk);
            #1;
            if (rd && fifo_q.size() > 0) bus.fifo_dout = fifo_q.pop_front();
            bus.fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Parser model: ready pulses d cycles after par_valid rises; fields are junk otherwise.
    initial begin
        bit act = 0;
        int cnt = 0;
        bus.par_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.par_valid) begin
                if (!act) begin act = 1; cnt = 0; end
                else cnt++;
            end else begin
                act = 0;
            end
            if (act && cnt == int'(bus.par_buffer[183:176])) begin
                bus.par_ready    = 1'b1;
                bus.par_req_type = bus.par_buffer[7:0];
                bus.par_side     = bus.par_buffer[15:8];
                bus.par_order_id = bus.par_buffer[47:16];
                bus.par_stock_id = bus.par_buffer[79:48];
                bus.par_quantity = bus.par_buffer[111:80];
                bus.par_price    = bus.par_buffer[175:112];
            end else begin
                bus.par_ready    = 1'b0;
                bus.par_req_type = 8'($urandom);
                bus.par_side     = 8'($urandom);
                bus.par_order_id = $urandom;
                bus.par_stock_id = $urandom;
                bus.par_quantity = $urandom;
                bus.par_price    = {$urandom, $urandom};
            end
        end
    end

    // Engine models: ready after the message's stall count; random while idle.
    initial begin
        bit bact = 0, sact = 0;
        int bcnt = 0, scnt = 0, stall;
        bus.buy_ready  = 1'b0;
        bus.sell_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stall = int'(bus.par_buffer[191:184]);
            if (bus.buy_valid) begin
                if (!bact) begin bact = 1; bcnt = 0; end else bcnt++;
                bus.buy_ready = (bcnt >= stall);
            end else begin
                bact = 0;
                bus.buy_ready = 1'($urandom_range(0, 1));
            end
            if (bus.sell_valid) begin
                if (!sact) begin sact = 1; scnt = 0; end else scnt++;
                bus.sell_ready = (scnt >= stall);
            end else begin
                sact = 0;
                bus.sell_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [CNT_W-1:0] prev_drop = '0;
        int   pv_run = 0, vrun = 0;
        bit   hs_buy, hs_sell;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_drop = '0;
                pv_run = 0;
                vrun = 0;
            end else begin
                if (bus.fifo_rd_en) begin
                    rd_times.push_back(cyc);
                    check("rd_en_only_when_nonempty", bus.fifo_empty, 0);
                end
                if (bus.buy_valid || bus.sell_valid) begin
                    check("one_engine_valid", bus.buy_valid & bus.sell_valid, 0);
                    vrun++;
                end else begin
                    vrun = 0;
                end
                if (bus.par_valid) pv_run++;
                else if (pv_run > 0) begin
                    if (exp_q.size() > 0) check("par_valid_len", pv_run, exp_q[0].pv_len);
                    else check("par_valid_unexpected", pv_run, 0);
                    pv_run = 0;
                end
                hs_buy  = bus.buy_valid && bus.buy_ready;
                hs_sell = bus.sell_valid && bus.sell_ready;
                if (hs_buy || hs_sell) begin
                    if (exp_q.size() == 0) check("dispatch_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("dispatch_kind", {e.drop, e.buy}, {1'b0, hs_buy});
                        check("ord_req_type", bus.ord_req_type, e.t);
                        check("ord_ids", {bus.ord_order_id, bus.ord_stock_id}, {e.oid, e.sid});
                        check("ord_quantity", bus.ord_quantity, e.qty);
                        check("ord_price", bus.ord_price, e.price);
                        check("valid_len", vrun, e.stall + 1);
                    end
                end
                if (drop_count == prev_drop + CNT_W'(1)) begin
                    if (exp_q.size() == 0) check("drop_unexpected", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("drop_kind", e.drop, 1);
                        if (e.parsed) begin
                            check("drop_ord_type_qty", {bus.ord_req_type, bus.ord_quantity}, {e.t, e.qty});
                            check("drop_ord_price", bus.ord_price, e.price);
                        end
                    end
                end
                prev_drop = drop_count;
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        logic [7:0] t, s;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Idle after reset with an empty FIFO.
        repeat (4) begin
            @(negedge clk);
            check("reset_ctrl_outs", {bus.fifo_rd_en, busy, bus.par_valid, bus.buy_valid, bus.sell_valid}, 0);
            check("reset_counters", {msg_count, drop_count}, 0);
        end
        check("reset_par_buffer", (bus.par_buffer == '0), 1);
        check("reset_ord", {bus.ord_req_type, bus.ord_quantity, bus.ord_order_id}, 0);
        check("reset_ord_price", bus.ord_price, 0);

        // Directed cases.
        send(8'h41, 8'h42, 32'h64, 64'h55, 2, 0);
        drain("buy_add");
        send(8'h44, 8'h53, 32'h1234, 64'hABCD, 1, 5);
        drain("sell_stall");
        send(8'h53, 8'h42, 32'h7, 64'h9, 0, 0);
        send(8'h41, 8'h55, 32'h8, 64'hA, 3, 0);
        drain("illegal");
        send(8'h41, 8'h42, 32'h11, 64'h22, 255, 0);
        send(8'h4D, 8'h53, 32'h33, 64'h44, PT - 1, 1);
        send(8'h41, 8'h53, 32'h55, 64'h66, PT, 0);
        send(8'h4D, 8'h42, 32'h77, 64'h88, 0, 2);
        drain("timeout");

        // Back-to-back messages with immediate readies.
        rd_times.delete();
        for (int i = 0; i < 3; i++) send(8'h41, (i == 1) ? 8'h53 : 8'h42, 32'(i + 1), 64'(i + 10), 0, 0);
        drain("b2b");
        check("b2b_pulses", rd_times.size(), 3);
        if (rd_times.size() >= 3) begin
            check("b2b_gap1", rd_times[1] - rd_times[0], 5);
            check("b2b_gap2", rd_times[2] - rd_times[1], 5);
        end

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: t = 8'h41; 1: t = 8'h4D; 2: t = 8'h44; 3: t = 8'h41;
                4: t = 8'h53; default: t = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0, 1: s = 8'h42; 2, 3: s = 8'h53; default: s = 8'($urandom);
            endcase
            send(t, s, $urandom, {$urandom, $urandom},
                 ($urandom_range(0, 99) < 85) ? $urandom_range(0, 4) : $urandom_range(PT - 2, PT + 2),
                 $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("random");

        // Reset while an order is waiting in DISPATCH.
        send(8'h41, 8'h42, 32'h99, 64'h98, 0, 200);
        n = 0;
        while (!bus.buy_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_dispatch", bus.buy_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_valids", {bus.buy_valid, bus.sell_valid, bus.par_valid}, 0);
        check("rst_counters", {msg_count, drop_count}, 0);
        check("rst_busy", busy, 0);
        exp_q.delete();
        fifo_q.delete();
        model_msg  = 0;
        model_drop = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(8'h44, 8'h53, 32'h5, 64'h6, 1, 1);
        drain("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
